hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit_pkg.sv | 28 ++
 rtl/hazard_fwd_sel.sv | 26 ++
 rtl/hazard_unit.sv | 159 +++++++++++++++
 tb/tb_hazard_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared pipeline package for the hazard unit: forward-select encodings,
// FSM state encoding, register/depth widths and a small depth helper.
package hazard_unit_pkg;

  localparam int unsigned REG_W   = 3;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned DEPTH_W = 2;

  // Comparator operand source select
  typedef enum logic [SEL_W-1:0] {
    FWD_MEM = 2'b00,
    FWD_WB  = 2'b01,
    FWD_RF  = 2'b10
  } fwd_sel_e;

  // Stall controller states
  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

  typedef logic [DEPTH_W-1:0] depth_t;

  function automatic depth_t max_depth(depth_t a, depth_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand comparator forward select.
// Ports: rs (source register), mem_rd/mem_regwrite/mem_memread (EX/MEM),
//        wb_rd/wb_regwrite (MEM/WB), sel (00 EX/MEM, 01 MEM/WB, 10 regfile).
module hazard_fwd_sel
  import hazard_unit_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_regwrite,
  input  logic             mem_memread,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_regwrite,
  output logic [SEL_W-1:0] sel
);

  // EX/MEM wins over MEM/WB; a load in EX/MEM has no data yet to forward
  always_comb begin : fwd_pick
    sel = FWD_RF;
    if (mem_regwrite && !mem_memread && (mem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_regwrite && (wb_rd == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Decode-stage hazard unit: load-use / branch-operand stall detection,
// comparator forwarding selects, branch/jump redirect and a saturating
// stall-cycle counter.
// Ports: CLK, Reset (async active-high); IF/ID sources Rs1/Rs2 with
//        uses_rs1/uses_rs2, is_branch, is_jump, jump (0 = taken);
//        ID/EX, EX/MEM, MEM/WB destinations and controls;
//        outputs comparatorMux1/2Control, PC_write, RB_write,
//        id_ex_flush, if_id_flush, pc_sel, stall_count.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [REG_W-1:0] Rs1,
  input  logic [REG_W-1:0] Rs2,
  input  logic             uses_rs1,
  input  logic             uses_rs2,
  input  logic             is_branch,
  input  logic             is_jump,
  input  logic             jump,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_regwrite,
  input  logic             mem_memread,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_regwrite,
  output logic [SEL_W-1:0] comparatorMux1Control,
  output logic [SEL_W-1:0] comparatorMux2Control,
  output logic             PC_write,
  output logic             RB_write,
  output logic             id_ex_flush,
  output logic             if_id_flush,
  output logic             pc_sel,
  output logic [CNT_W-1:0] stall_count
);

  state_e         state, state_n;
  logic [1:0]     remain, remain_n;
  depth_t         depth;
  logic           stall;
  logic [SEL_W-1:0] sel1, sel2;

  // Stall depth required by one source operand
  function automatic depth_t op_depth(logic uses, logic ex_hit, logic mem_hit,
                                      logic branch, logic ex_rw, logic ex_mr,
                                      logic mem_mr);
    depth_t d;
    d = '0;
    if (uses && ex_mr && ex_hit) d = 2'd1;
    if (branch) begin
      if (ex_rw && !ex_mr && ex_hit) d = max_depth(d, 2'd1);
      if (ex_mr && ex_hit)           d = 2'd2;
      if (mem_mr && mem_hit)         d = max_depth(d, 2'd1);
    end
    return d;
  endfunction

  always_comb begin : depth_calc
    depth = max_depth(
      op_depth(uses_rs1, ex_rd == Rs1, mem_rd == Rs1, is_branch,
               ex_regwrite, ex_memread, mem_memread),
      op_depth(uses_rs2, ex_rd == Rs2, mem_rd == Rs2, is_branch,
               ex_regwrite, ex_memread, mem_memread));
  end

  hazard_fwd_sel u_fwd1 (
    .rs           (Rs1),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .mem_memread  (mem_memread),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .sel          (sel1)
  );

  hazard_fwd_sel u_fwd2 (
    .rs           (Rs2),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .mem_memread  (mem_memread),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .sel          (sel2)
  );

  // State and counter registers
  always_ff @(posedge CLK or posedge Reset) begin : state_reg
    if (Reset) begin
      state       <= RUN;
      remain      <= '0;
      stall_count <= '0;
    end else begin
      state  <= state_n;
      remain <= remain_n;
      if (stall && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

  // Next state; stall is combinational so the detection cycle itself stalls
  always_comb begin : fsm_next
    state_n  = state;
    remain_n = remain;
    stall    = 1'b0;
    case (state)
      RUN: begin
        if (depth != '0) stall = 1'b1;
        if (depth == 2'd2) begin
          state_n  = HOLD;
          remain_n = 2'd1;
        end
      end
      HOLD: begin
        stall = 1'b1;
        if (remain <= 2'd1) begin
          remain_n = '0;
          state_n  = RUN;
        end else begin
          remain_n = remain - 2'd1;
        end
      end
      default: begin
        state_n  = RUN;
        remain_n = '0;
      end
    endcase
  end

  // Outputs; Reset forces the idle values without waiting for a clock
  always_comb begin : out_logic
    PC_write              = 1'b1;
    RB_write              = 1'b1;
    id_ex_flush           = 1'b0;
    if_id_flush           = 1'b0;
    pc_sel                = 1'b0;
    comparatorMux1Control = FWD_RF;
    comparatorMux2Control = FWD_RF;
    if (!Reset) begin
      if (stall) begin
        PC_write    = 1'b0;
        RB_write    = 1'b0;
        id_ex_flush = 1'b1;
      end else begin
        comparatorMux1Control = sel1;
        comparatorMux2Control = sel2;
        if ((is_branch && !jump) || is_jump) begin
          pc_sel      = 1'b1;
          if_id_flush = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit (CNT_W = 4 so saturation is reachable).
module tb_hazard_unit;

  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [2:0] Rs1, Rs2, ex_rd, mem_rd, wb_rd;
  logic       uses_rs1, uses_rs2, is_branch, is_jump, jump;
  logic       ex_regwrite, ex_memread, mem_regwrite, mem_memread, wb_regwrite;
  logic [1:0] comparatorMux1Control, comparatorMux2Control;
  logic       PC_write, RB_write, id_ex_flush, if_id_flush, pc_sel;
  logic [CW-1:0] stall_count;

  int n_vec = 0;
  int n_err = 0;
  int m_hold = 0;
  int m_cnt  = 0;

  hazard_unit #(.CNT_W(CW)) dut (
    .CLK(CLK), .Reset(Reset), .Rs1(Rs1), .Rs2(Rs2),
    .uses_rs1(uses_rs1), .uses_rs2(uses_rs2),
    .is_branch(is_branch), .is_jump(is_jump), .jump(jump),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .comparatorMux1Control(comparatorMux1Control),
    .comparatorMux2Control(comparatorMux2Control),
    .PC_write(PC_write), .RB_write(RB_write),
    .id_ex_flush(id_ex_flush), .if_id_flush(if_id_flush),
    .pc_sel(pc_sel), .stall_count(stall_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: stall depth needed by one operand
  function automatic int need(input int rs, input bit uses);
    int d = 0;
    if (uses && ex_memread && int'(ex_rd) == rs) d = 1;
    if (is_branch) begin
      if (ex_regwrite && !ex_memread && int'(ex_rd) == rs && d < 1) d = 1;
      if (ex_memread && int'(ex_rd) == rs) d = 2;
      if (mem_memread && int'(mem_rd) == rs && d < 1) d = 1;
    end
    return d;
  endfunction

  function automatic int depth_now();
    int a = need(int'(Rs1), uses_rs1);
    int b = need(int'(Rs2), uses_rs2);
    return (a > b) ? a : b;
  endfunction

  function automatic int fwd(input int rs);
    if (mem_regwrite && !mem_memread && int'(mem_rd) == rs) return 0;
    if (wb_regwrite && int'(wb_rd) == rs) return 1;
    return 2;
  endfunction

  function automatic bit exp_stall();
    return !Reset && (m_hold > 0 || depth_now() > 0);
  endfunction

  task automatic check_all(input string tag);
    bit s   = exp_stall();
    bit red = !Reset && !s && ((is_branch && !jump) || is_jump);
    chk({tag, ".pc_write"}, int'(PC_write), int'(!s));
    chk({tag, ".rb_write"}, int'(RB_write), int'(!s));
    chk({tag, ".id_ex_flush"}, int'(id_ex_flush), int'(s));
    chk({tag, ".if_id_flush"}, int'(if_id_flush), int'(red));
    chk({tag, ".pc_sel"}, int'(pc_sel), int'(red));
    chk({tag, ".stall_count"}, int'(stall_count), m_cnt);
    if (Reset) begin
      chk({tag, ".mux1"}, int'(comparatorMux1Control), 2);
      chk({tag, ".mux2"}, int'(comparatorMux2Control), 2);
    end else if (!s) begin
      chk({tag, ".mux1"}, int'(comparatorMux1Control), fwd(int'(Rs1)));
      chk({tag, ".mux2"}, int'(comparatorMux2Control), fwd(int'(Rs2)));
    end
  endtask

  // One clock edge with the reference model stepped alongside
  task automatic advance();
    bit s = exp_stall();
    int d = depth_now();
    @(posedge CLK);
    if (Reset) begin
      m_hold = 0;
      m_cnt  = 0;
    end else begin
      if (m_hold > 0) m_hold--;
      else if (d == 2) m_hold = 1;
      if (s && m_cnt < CMAX) m_cnt++;
    end
    #1;
  endtask

  task automatic idle();
    Rs1 = 3'd0; Rs2 = 3'd0; uses_rs1 = 0; uses_rs2 = 0;
    is_branch = 0; is_jump = 0; jump = 1;
    ex_rd = 3'd7; ex_regwrite = 0; ex_memread = 0;
    mem_rd = 3'd7; mem_regwrite = 0; mem_memread = 0;
    wb_rd = 3'd7; wb_regwrite = 0;
  endtask

  task automatic randomize_inputs();
    Rs1 = 3'($urandom); Rs2 = 3'($urandom);
    uses_rs1 = 1'($urandom); uses_rs2 = 1'($urandom);
    is_branch = ($urandom_range(3) == 0); is_jump = ($urandom_range(7) == 0);
    jump = 1'($urandom);
    ex_rd = 3'($urandom); ex_regwrite = 1'($urandom); ex_memread = ($urandom_range(3) == 0);
    mem_rd = 3'($urandom); mem_regwrite = 1'($urandom); mem_memread = ($urandom_range(3) == 0);
    wb_rd = 3'($urandom); wb_regwrite = 1'($urandom);
  endtask

  task automatic do_reset();
    Reset = 1; #1;
    m_hold = 0; m_cnt = 0;
    advance();
    Reset = 0; #1;
  endtask

  initial begin
    idle();
    Reset = 1;
    randomize_inputs();
    #2;
    check_all("reset");
    @(posedge CLK); #1;
    Reset = 0;
    idle(); #1;
    check_all("idle");

    // Load-use single stall
    ex_memread = 1; ex_rd = 3'd3; Rs1 = 3'd3; uses_rs1 = 1; #1;
    check_all("loaduse");
    advance();
    idle(); #1;
    check_all("loaduse_after");
    chk("loaduse.count1", int'(stall_count), 1);

    // Branch after load: two stall cycles
    do_reset();
    is_branch = 1; Rs2 = 3'd5; ex_memread = 1; ex_rd = 3'd5; #1;
    check_all("brload0");
    advance();
    check_all("brload1");
    chk("brload1.stall", int'(id_ex_flush), 1);
    advance();
    idle(); #1;
    check_all("brload_done");
    chk("brload.count2", int'(stall_count), 2);

    // Forwarding priority
    mem_regwrite = 1; mem_rd = 3'd2; wb_regwrite = 1; wb_rd = 3'd2; Rs1 = 3'd2; #1;
    chk("fwd.mem", int'(comparatorMux1Control), 0);
    mem_regwrite = 0; #1;
    chk("fwd.wb", int'(comparatorMux1Control), 1);
    wb_regwrite = 0; #1;
    chk("fwd.rf", int'(comparatorMux1Control), 2);
    advance();

    // Taken branch, then taken branch blocked by a hazard
    idle(); is_branch = 1; jump = 0; Rs1 = 3'd4; #1;
    check_all("taken");
    chk("taken.pc_sel", int'(pc_sel), 1);
    advance();
    ex_rd = 3'd4; ex_regwrite = 1; #1;
    check_all("taken_haz");
    chk("taken_haz.pc_sel", int'(pc_sel), 0);
    advance();

    // Reset while in HOLD
    idle(); do_reset();
    is_branch = 1; Rs1 = 3'd6; ex_memread = 1; ex_rd = 3'd6; #1;
    advance();
    #2; Reset = 1; #1;
    m_hold = 0; m_cnt = 0;
    check_all("rst_hold");
    #1; Reset = 0; idle(); #1;
    check_all("rst_hold_run");
    chk("rst_hold.pc_write", int'(PC_write), 1);
    advance();

    // Saturation
    do_reset();
    ex_memread = 1; ex_rd = 3'd1; Rs1 = 3'd1; uses_rs1 = 1;
    for (int i = 0; i < 20; i++) begin
      #1; check_all("sat");
      advance();
    end
    idle(); #1;
    chk("sat.count", int'(stall_count), CMAX);

    // Random traffic with occasional asynchronous resets
    do_reset();
    for (int i = 0; i < 400; i++) begin
      randomize_inputs(); #1;
      check_all("rnd");
      if ($urandom_range(59) == 0) begin
        #1; Reset = 1; #1;
        m_hold = 0; m_cnt = 0;
        check_all("rnd_rst");
        advance();
        Reset = 0; #1;
      end else begin
        advance();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
